nios_dbg_ocimem_arbiter: RTL and testbench

Arbitrates the single-port on-chip debug RAM (OCI memory) between two requesters: JTAG debug commands, arriving as one-cycle action strobes plus the 38-bit jdo word from the debug slave's sysclk stage, and CPU monitor accesses on an Avalon-MM slave port. It owns the JTAG auto-incrementing address register, a one-deep JTAG command slot, and round-robin arbitration. It returns JTAG read data in MonDReg and reports status through monitor_ready and monitor_error.

---
 rtl/nios_dbg_ocimem_arbiter_if.sv | 45 ++++
 rtl/nios_dbg_ocimem_arbiter.sv | 127 ++++++++++++
 tb/tb_nios_dbg_ocimem_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_dbg_ocimem_arbiter_if.sv
// Signal bundle for the OCI memory arbiter: JTAG command strobes, the CPU
// Avalon-MM slave port and the single-port debug RAM port.
interface nios_dbg_ocimem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned JDO_W = 38;

    logic              jtag_ld_addr;
    logic              jtag_wr;
    logic              jtag_rd;
    logic [JDO_W-1:0]  jdo;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_writedata;
    logic              cpu_waitrequest;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_readdatavalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport slave (
        input  jtag_ld_addr, jtag_wr, jtag_rd, jdo,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata,
        output cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        output ram_addr, ram_wren, ram_wdata,
        input  ram_q,
        output MonDReg, monitor_ready, monitor_error
    );

    modport master (
        output jtag_ld_addr, jtag_wr, jtag_rd, jdo,
        output cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  cpu_waitrequest, cpu_readdata, cpu_readdatavalid,
        input  ram_addr, ram_wren, ram_wdata,
        output ram_q,
        input  MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/nios_dbg_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI debug RAM between JTAG
// debug commands (one-deep slot, auto-incrementing address) and CPU accesses.
module nios_dbg_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic                      clk,
    input logic                      reset_n,
    nios_dbg_ocimem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_CPU, RD_JTAG} state_t;
    typedef enum logic {GRANT_CPU, GRANT_JTAG} grant_t;

    state_t            state_q, state_d;
    grant_t            last_grant_q;
    logic [ADDR_W-1:0] jtag_addr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic              jp_q;
    logic              jtag_is_wr_q;
    logic [DATA_W-1:0] jtag_wdata_q;
    logic [DATA_W-1:0] mon_dreg_q;
    logic              monitor_error_q;

    logic              cpu_req;
    logic              jtag_strobe;
    logic              cpu_grant;
    logic              jtag_grant;
    logic              jtag_done;
    logic [ADDR_W-1:0] ram_addr_c;
    logic              ram_wren_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              jdo_unused;

    assign cpu_req     = bus.cpu_read | bus.cpu_write;
    assign jtag_strobe = bus.jtag_ld_addr | bus.jtag_wr | bus.jtag_rd;
    assign jdo_unused  = ^{bus.jdo[37:35], bus.jdo[2:0]};

    // Grant selection and RAM port steering; grants only issue from IDLE.
    always_comb begin
        state_d     = state_q;
        cpu_grant   = 1'b0;
        jtag_grant  = 1'b0;
        jtag_done   = 1'b0;
        ram_addr_c  = ram_addr_q;
        ram_wren_c  = 1'b0;
        ram_wdata_c = jtag_wdata_q;
        case (state_q)
            IDLE: begin
                if (reset_n) begin
                    if (jp_q && cpu_req) begin
                        jtag_grant = (last_grant_q == GRANT_CPU);
                        cpu_grant  = (last_grant_q == GRANT_JTAG);
                    end else begin
                        jtag_grant = jp_q;
                        cpu_grant  = cpu_req;
                    end
                end
                if (cpu_grant) begin
                    ram_addr_c  = bus.cpu_address;
                    ram_wren_c  = bus.cpu_write;
                    ram_wdata_c = bus.cpu_writedata;
                    if (!bus.cpu_write) state_d = RD_CPU;
                end else if (jtag_grant) begin
                    ram_addr_c = jtag_addr_q;
                    ram_wren_c = jtag_is_wr_q;
                    if (jtag_is_wr_q) jtag_done = 1'b1;
                    else              state_d   = RD_JTAG;
                end
            end
            RD_CPU:  state_d = IDLE;
            RD_JTAG: begin
                state_d   = IDLE;
                jtag_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // JTAG slot, address register, overflow flag and read-data capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jtag_addr_q     <= '0;
            ram_addr_q      <= '0;
            jp_q            <= 1'b0;
            jtag_is_wr_q    <= 1'b0;
            jtag_wdata_q    <= '0;
            last_grant_q    <= GRANT_CPU;
            mon_dreg_q      <= '0;
            monitor_error_q <= 1'b0;
        end else begin
            if (cpu_grant || jtag_grant) begin
                ram_addr_q   <= ram_addr_c;
                last_grant_q <= cpu_grant ? GRANT_CPU : GRANT_JTAG;
            end
            if (state_q == RD_JTAG) mon_dreg_q <= bus.ram_q;
            if (jp_q) begin
                if (jtag_done) begin
                    jp_q        <= 1'b0;
                    jtag_addr_q <= jtag_addr_q + ADDR_W'(1);
                end
                if (jtag_strobe) monitor_error_q <= 1'b1;
            end else if (bus.jtag_ld_addr) begin
                jtag_addr_q     <= bus.jdo[17+ADDR_W:18];
                monitor_error_q <= bus.jtag_wr | bus.jtag_rd;
            end else if (bus.jtag_wr || bus.jtag_rd) begin
                jp_q         <= 1'b1;
                jtag_is_wr_q <= bus.jtag_wr;
                jtag_wdata_q <= bus.jdo[2+DATA_W:3];
            end
        end
    end

    assign bus.cpu_waitrequest   = cpu_req & ~cpu_grant;
    assign bus.cpu_readdata      = bus.ram_q;
    assign bus.cpu_readdatavalid = reset_n & (state_q == RD_CPU);
    assign bus.ram_addr          = ram_addr_c;
    assign bus.ram_wren          = ram_wren_c;
    assign bus.ram_wdata         = ram_wdata_c;
    assign bus.MonDReg           = mon_dreg_q;
    assign bus.monitor_ready     = ~jp_q;
    assign bus.monitor_error     = monitor_error_q;
endmodule

// File: tb/tb_nios_dbg_ocimem_arbiter.sv
// Scoreboard bench for the OCI memory arbiter: transaction-level memory model,
// expected-response queues and a negedge monitor.
`timescale 1ns/1ps
module tb_nios_dbg_ocimem_arbiter;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_dbg_ocimem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    nios_dbg_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    // Single-port RAM with one-cycle read latency.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr];
    end

    typedef struct { bit rd; logic [DATA_W-1:0] data; } jexp_t;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [ADDR_W-1:0] jaddr;
    logic [DATA_W-1:0] cpu_q [$];
    jexp_t             jtag_q [$];
    int                ev_log [$];
    bit                log_en = 1'b0;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes a transaction.
    initial begin : monitor
        bit    prev_ready;
        bit    prev_rd_grant;
        jexp_t e;
        prev_ready    = 1'b1;
        prev_rd_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rdv_in_reset", 32'(bus.cpu_readdatavalid), 32'd0);
                prev_ready    = 1'b1;
                prev_rd_grant = 1'b0;
            end else begin
                if (bus.cpu_readdatavalid || prev_rd_grant)
                    check("cpu_rdv_timing", 32'(bus.cpu_readdatavalid), 32'(prev_rd_grant));
                if (bus.cpu_readdatavalid) begin
                    if (cpu_q.size() == 0) check("cpu_rdv_unexpected", 32'(bus.cpu_readdatavalid), 32'd0);
                    else check("cpu_readdata", bus.cpu_readdata, cpu_q.pop_front());
                    if (log_en) ev_log.push_back(2);
                end
                if (bus.monitor_ready && !prev_ready) begin
                    if (jtag_q.size() == 0) check("jtag_done_unexpected", 32'(bus.monitor_ready), 32'd0);
                    else begin
                        e = jtag_q.pop_front();
                        if (e.rd) check("MonDReg", bus.MonDReg, e.data);
                    end
                    if (log_en) ev_log.push_back(1);
                end
                prev_ready    = bus.monitor_ready;
                prev_rd_grant = bus.cpu_read && !bus.cpu_write && !bus.cpu_waitrequest;
            end
        end
    end

    task automatic model_jwr(input logic [DATA_W-1:0] d);
        jexp_t e;
        ref_mem[jaddr] = d;
        e.rd = 1'b0; e.data = d;
        jtag_q.push_back(e);
        jaddr = jaddr + ADDR_W'(1);
    endtask

    task automatic model_jrd();
        jexp_t e;
        e.rd = 1'b1; e.data = ref_mem[jaddr];
        jtag_q.push_back(e);
        jaddr = jaddr + ADDR_W'(1);
    endtask

    // Avalon master: called at posedge+1, returns at posedge+1 after the grant.
    task automatic cpu_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int waited);
        int n;
        n = 0;
        bus.cpu_address = a; bus.cpu_writedata = d;
        bus.cpu_write = wr;  bus.cpu_read = ~wr;
        @(negedge clk);
        while (bus.cpu_waitrequest && n < 64) begin @(negedge clk); n++; end
        if (bus.cpu_waitrequest) check("cpu_grant_timeout", 32'(bus.cpu_waitrequest), 32'd0);
        else if (wr) ref_mem[a] = d;
        else cpu_q.push_back(ref_mem[a]);
        waited = n;
        @(posedge clk); #1;
        bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    endtask

    // JTAG command: waits for an empty slot; kind 0=load address, 1=write, 2=read.
    task automatic jtag_cmd(input int kind, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        int n;
        n = 0;
        while (!bus.monitor_ready && n < 64) begin @(posedge clk); #1; n++; end
        check("jtag_ready_wait", 32'(bus.monitor_ready), 32'd1);
        bus.jdo = {6'($urandom), 32'($urandom)};
        case (kind)
            0: begin bus.jdo[17+ADDR_W:18] = a; bus.jtag_ld_addr = 1'b1; jaddr = a; end
            1: begin bus.jdo[2+DATA_W:3] = d; bus.jtag_wr = 1'b1; model_jwr(d); end
            default: begin bus.jtag_rd = 1'b1; model_jrd(); end
        endcase
        @(posedge clk); #1;
        bus.jtag_ld_addr = 1'b0; bus.jtag_wr = 1'b0; bus.jtag_rd = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((!bus.monitor_ready || cpu_q.size() != 0 || jtag_q.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("drain_pending", 32'(cpu_q.size() + jtag_q.size()) + 32'(!bus.monitor_ready), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int w;
        bus.jtag_ld_addr = 1'b0; bus.jtag_wr = 1'b0; bus.jtag_rd = 1'b0; bus.jdo = '0;
        bus.cpu_address = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_writedata = '0;
        jaddr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_monitor_ready", 32'(bus.monitor_ready), 32'd1);
        check("rst_monitor_error", 32'(bus.monitor_error), 32'd0);
        check("rst_MonDReg", bus.MonDReg, 32'd0);
        check("rst_ram_wren", 32'(bus.ram_wren), 32'd0);
        check("rst_waitrequest", 32'(bus.cpu_waitrequest), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < int'(DEPTH); i++) cpu_op(1'b1, ADDR_W'(i), $urandom, w);

        // JTAG load / write / read with auto-increment
        jtag_cmd(0, '0, ADDR_W'(8'h10));
        jtag_cmd(1, 32'hDEAD_BEEF, '0);
        jtag_cmd(2, '0, '0);
        jtag_cmd(1, 32'h1234_5678, '0);
        drain();
        check("jtag_wr_0x10", mem[8'h10], 32'hDEAD_BEEF);
        check("jtag_addr_0x12", mem[8'h12], 32'h1234_5678);

        // CPU write then read, uncontended
        cpu_op(1'b1, ADDR_W'(8'h20), 32'hA5A5_A5A5, w);
        check("cpu_wr_wait", 32'(w), 32'd0);
        cpu_op(1'b0, ADDR_W'(8'h20), '0, w);
        check("cpu_rd_wait", 32'(w), 32'd0);
        drain();

        // Strobe while the slot is full is dropped and flagged
        bus.cpu_address = ADDR_W'(8'h30); bus.cpu_read = 1'b1;
        bus.jdo = {3'd0, 32'h0BAD_F00D, 3'd0}; bus.jtag_wr = 1'b1;
        cpu_q.push_back(ref_mem[8'h30]);
        model_jwr(32'h0BAD_F00D);
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
        bus.jdo = {3'd0, 32'hFFFF_FFFF, 3'd0};
        @(posedge clk); #1;
        bus.jtag_wr = 1'b0;
        check("overflow_error_set", 32'(bus.monitor_error), 32'd1);
        drain();
        check("overflow_error_sticky", 32'(bus.monitor_error), 32'd1);
        jtag_cmd(0, '0, ADDR_W'(8'h40));
        check("ld_clears_error", 32'(bus.monitor_error), 32'd0);

        // Load coincident with a write: load applies, write dropped
        bus.jdo = '0; bus.jdo[17+ADDR_W:18] = ADDR_W'(8'h50);
        bus.jtag_ld_addr = 1'b1; bus.jtag_wr = 1'b1;
        jaddr = ADDR_W'(8'h50);
        @(posedge clk); #1;
        bus.jtag_ld_addr = 1'b0; bus.jtag_wr = 1'b0;
        check("ld_wr_error", 32'(bus.monitor_error), 32'd1);
        check("ld_wr_dropped", 32'(bus.monitor_ready), 32'd1);
        jtag_cmd(1, 32'hC0FF_EE00, '0);
        jtag_cmd(0, '0, ADDR_W'(8'h60));
        check("ld_clears_error2", 32'(bus.monitor_error), 32'd0);

        // Address wrap
        jtag_cmd(0, '0, ADDR_W'(8'hFF));
        jtag_cmd(1, 32'h1111_2222, '0);
        jtag_cmd(1, 32'h3333_4444, '0);
        drain();
        check("wrap_0xFF", mem[8'hFF], 32'h1111_2222);
        check("wrap_0x00", mem[8'h00], 32'h3333_4444);

        // Reset during RD_CPU with a JTAG command pending
        bus.cpu_address = ADDR_W'(8'h21); bus.cpu_read = 1'b1; bus.jtag_rd = 1'b1;
        @(posedge clk); #1;
        bus.cpu_read = 1'b0; bus.jtag_rd = 1'b0;
        check("pre_reset_jp", 32'(bus.monitor_ready), 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        jaddr = '0;
        check("post_reset_ready", 32'(bus.monitor_ready), 32'd1);
        check("post_reset_MonDReg", bus.MonDReg, 32'd0);
        check("post_reset_error", 32'(bus.monitor_error), 32'd0);

        // Contended alternation, JTAG first after reset
        ev_log.delete(); log_en = 1'b1;
        fork
            begin for (int k = 0; k < 6; k++) jtag_cmd(2, '0, '0); end
            begin
                int wa;
                @(posedge clk); #1;
                for (int k = 0; k < 6; k++) cpu_op(1'b0, ADDR_W'(8'h40 + k), '0, wa);
            end
        join
        drain();
        log_en = 1'b0;
        check("alt_len", 32'(ev_log.size()), 32'd12);
        for (int i = 0; i < ev_log.size() && i < 12; i++)
            check($sformatf("alt_order[%0d]", i), 32'(ev_log[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

        // After a JTAG grant, a simultaneous request goes to the CPU
        ev_log.delete(); log_en = 1'b1;
        jtag_cmd(1, 32'h5555_0000, '0);
        jtag_cmd(1, 32'h5555_0001, '0);
        cpu_op(1'b0, ADDR_W'(8'h22), '0, w);
        drain();
        log_en = 1'b0;
        check("rr_len", 32'(ev_log.size()), 32'd3);
        for (int i = 0; i < ev_log.size() && i < 3; i++)
            check($sformatf("rr_order[%0d]", i), 32'(ev_log[i]), (i == 1) ? 32'd2 : 32'd1);

        // Randomized concurrent traffic in disjoint regions
        fork
            begin
                jtag_cmd(0, '0, ADDR_W'(8'h80));
                for (int k = 0; k < 60; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    jtag_cmd(($urandom_range(0, 1) == 1) ? 1 : 2, $urandom, '0);
                end
            end
            begin
                int wr_n;
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    cpu_op(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 127)), $urandom, wr_n);
                end
            end
        join
        drain();

        for (int i = 0; i < int'(DEPTH); i++)
            check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
